// File: rtl/llr_frame_loader.sv
// Purpose: saturate incoming channel LLRs and collect one n-LLR codeword frame for the decoder.
// Latency: a beat is stored at its acceptance edge; rd_llr is valid one cycle after rd_addr.
// Backpressure: s_ready is low while a complete frame is held, until frame_done releases it.
module llr_frame_loader #(
  parameter int log2n = 4,
  parameter int n     = 12,
  parameter int in_w  = 8,
  parameter int llr_w = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [in_w-1:0]  s_llr,
  output logic             s_ready,
  input  logic             flush,
  output logic             frame_valid,
  output logic             frame_start,
  input  logic             frame_done,
  input  logic [log2n-1:0] rd_addr,
  output logic [llr_w-1:0] rd_llr,
  output logic [n-1:0]     hard_bits,
  output logic [log2n-1:0] load_count
);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  // Symmetric clamp magnitude: the most negative code is never stored.
  localparam int                      SAT_MAG  = (2 ** (llr_w - 1)) - 1;
  localparam logic signed [in_w-1:0]  IN_MAX   = in_w'(SAT_MAG);
  localparam logic signed [in_w-1:0]  IN_MIN   = in_w'(-SAT_MAG);
  localparam logic [llr_w-1:0]        LLR_MAX  = llr_w'(SAT_MAG);
  localparam logic [llr_w-1:0]        LLR_MIN  = llr_w'(-SAT_MAG);
  localparam logic [log2n-1:0]        IDX_LAST = log2n'(n - 1);

  state_t             state_q, state_d;
  logic [log2n-1:0]   load_count_q, load_count_d;
  logic               frame_start_q, frame_start_d;
  logic [llr_w-1:0]   rd_llr_q;
  logic [llr_w-1:0]   mem_q [n];
  logic               wr_en;
  logic signed [in_w-1:0] s_llr_s;
  logic [llr_w-1:0]   sat_llr;

  assign s_llr_s     = $signed(s_llr);
  assign s_ready     = (state_q == LOAD);
  assign frame_valid = (state_q == FULL);
  assign frame_start = frame_start_q;
  assign load_count  = load_count_q;
  assign rd_llr      = rd_llr_q;

  // Clamp the input LLR into the stored width, keeping the sign.
  always_comb begin
    sat_llr = s_llr_s[llr_w-1:0];
    if (s_llr_s > IN_MAX) begin
      sat_llr = LLR_MAX;
    end else if (s_llr_s < IN_MIN) begin
      sat_llr = LLR_MIN;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, fill counter, start pulse and write enable; flush only acts while loading.
  always_comb begin
    state_d       = state_q;
    load_count_d  = load_count_q;
    frame_start_d = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      LOAD: begin
        if (flush) begin
          load_count_d = '0;
        end else if (s_valid) begin
          wr_en = 1'b1;
          if (load_count_q == IDX_LAST) begin
            load_count_d  = '0;
            state_d       = FULL;
            frame_start_d = 1'b1;
          end else begin
            load_count_d = load_count_q + log2n'(1);
          end
        end
      end
      FULL: begin
        if (frame_done) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Fill counter and one-cycle start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count_q  <= '0;
      frame_start_q <= 1'b0;
    end else begin
      load_count_q  <= load_count_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Frame storage; cleared by reset so no partial frame survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < n; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[load_count_q] <= sat_llr;
    end
  end

  // Registered random read; addresses past the frame return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_llr_q <= '0;
    end else if (rd_addr <= IDX_LAST) begin
      rd_llr_q <= mem_q[rd_addr];
    end else begin
      rd_llr_q <= '0;
    end
  end

  // Hard decisions are the sign bits of the stored LLRs, straight from the storage flops.
  always_comb begin
    hard_bits = '0;
    for (int i = 0; i < n; i++) begin
      hard_bits[i] = mem_q[i][llr_w-1];
    end
  end

endmodule

// File: tb/tb_llr_frame_loader.sv
// Purpose: exercise llr_frame_loader against a cycle-level reference of the frame loader.
// Latency: expected read data is queued when rd_addr is driven and compared one edge later.
// Backpressure: beats offered while a frame is held must be ignored by the reference and DUT.
module tb_llr_frame_loader;

  localparam int LOG2N = 4;
  localparam int N     = 12;
  localparam int IN_W  = 8;
  localparam int LLR_W = 6;
  localparam int LMAX  = (1 << (LLR_W - 1)) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             s_valid = 1'b0;
  logic [IN_W-1:0]  s_llr = '0;
  logic             s_ready;
  logic             flush = 1'b0;
  logic             frame_valid;
  logic             frame_start;
  logic             frame_done = 1'b0;
  logic [LOG2N-1:0] rd_addr = '0;
  logic [LLR_W-1:0] rd_llr;
  logic [N-1:0]     hard_bits;
  logic [LOG2N-1:0] load_count;

  llr_frame_loader #(.log2n(LOG2N), .n(N), .in_w(IN_W), .llr_w(LLR_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_llr(s_llr), .s_ready(s_ready),
    .flush(flush), .frame_valid(frame_valid), .frame_start(frame_start),
    .frame_done(frame_done), .rd_addr(rd_addr), .rd_llr(rd_llr),
    .hard_bits(hard_bits), .load_count(load_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int m_mem [N];
  int m_cnt;
  bit m_full;
  bit m_start;
  int starts;
  int sb [$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int sat(input int v);
    if (v > LMAX) return LMAX;
    if (v < -LMAX) return -LMAX;
    return v;
  endfunction

  function automatic int exp_hard();
    int h = 0;
    for (int i = 0; i < N; i++) if (m_mem[i] < 0) h |= (1 << i);
    return h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_mem[i] = 0;
    m_cnt = 0; m_full = 0; m_start = 0;
    sb.delete();
  endtask

  // One clock: advance the reference with the inputs currently driven, then compare after the edge.
  task automatic cycle();
    int rd_exp;
    rd_exp = (int'(rd_addr) < N) ? m_mem[rd_addr] : 0;
    sb.push_back(rd_exp);
    m_start = 0;
    if (m_full) begin
      if (frame_done) m_full = 0;
    end else if (flush) begin
      m_cnt = 0;
    end else if (s_valid) begin
      m_mem[m_cnt] = sat(int'($signed(s_llr)));
      if (m_cnt == N - 1) begin
        m_cnt = 0; m_full = 1; m_start = 1;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (frame_start) starts++;
    check("rd_llr", int'($signed(rd_llr)), sb.pop_front());
    check("load_count", int'(load_count), m_cnt);
    check("frame_valid", int'(frame_valid), int'(m_full));
    check("frame_start", int'(frame_start), int'(m_start));
    check("s_ready", int'(s_ready), int'(!m_full));
    check("hard_bits", int'(hard_bits), exp_hard());
  endtask

  task automatic beat(input int v);
    s_valid = 1'b1;
    s_llr   = IN_W'(v);
    rd_addr = LOG2N'($urandom_range(0, 15));
    cycle();
    s_valid = 1'b0;
  endtask

  // Sweep every address, including those past the frame, while junk beats are offered.
  task automatic read_all();
    s_valid = 1'b1;
    s_llr   = IN_W'(77);
    for (int a = 0; a < 16; a++) begin
      rd_addr = LOG2N'(a);
      cycle();
    end
    s_valid = 1'b0;
  endtask

  task automatic release_frame();
    frame_done = 1'b1;
    cycle();
    frame_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_count"}, int'(load_count), 0);
    check({tag, "_frame_valid"}, int'(frame_valid), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_s_ready"}, int'(s_ready), 1);
    check({tag, "_rd_llr"}, int'(rd_llr), 0);
    check({tag, "_hard_bits"}, int'(hard_bits), 0);
  endtask

  initial begin
    int sat_vals [N];
    int guard;
    sat_vals = '{100, -128, -32, 31, -31, 5, 0, -1, 127, -127, 32, -33};

    // Power-on reset.
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Continuous load of 0..11, then sweep reads with beats offered while full.
    starts = 0;
    for (int i = 0; i < N; i++) beat(i);
    read_all();
    check("start_pulses", starts, 1);
    release_frame();

    // Saturation of out-of-range values.
    for (int i = 0; i < N; i++) beat(sat_vals[i]);
    check("sat_signs", int'(hard_bits[5:0]), 6'b010110);
    read_all();
    release_frame();

    // Random bubbles until a frame completes.
    guard = 0;
    while (!m_full && guard < 300) begin
      s_valid = 1'($urandom_range(0, 1));
      s_llr   = IN_W'($urandom_range(0, 255));
      rd_addr = LOG2N'($urandom_range(0, 15));
      cycle();
      guard++;
    end
    s_valid = 1'b0;
    check("rand_bound", int'(guard < 300), 1);
    read_all();
    release_frame();

    // Flush with a simultaneous beat after five beats.
    for (int i = 0; i < 5; i++) beat(-10 - i);
    flush = 1'b1; s_valid = 1'b1; s_llr = IN_W'(50);
    cycle();
    flush = 1'b0; s_valid = 1'b0;
    check("flush_count", int'(load_count), 0);
    for (int i = 0; i < N; i++) beat(20 - 3 * i);
    read_all();
    release_frame();

    // Release together with flush, immediate refill, frame_done pulse ignored while loading.
    for (int i = 0; i < N; i++) beat(i - 6);
    frame_done = 1'b1; flush = 1'b1;
    cycle();
    frame_done = 1'b0; flush = 1'b0;
    check("release_fv", int'(frame_valid), 0);
    starts = 0;
    for (int i = 0; i < N; i++) begin
      if (i == 3) frame_done = 1'b1;
      beat(2 * i - 11);
      frame_done = 1'b0;
    end
    check("refill_fv", int'(frame_valid), 1);
    check("refill_starts", starts, 1);
    read_all();
    release_frame();

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 7; i++) beat(-20 + i);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    read_all();
    for (int i = 0; i < N; i++) beat(40 - 7 * i);
    read_all();
    release_frame();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
